// File: rtl/hamming_seq_ctrl.sv
// Sequencer for the program-1 Hamming(16,11) encode pass.
// For each message it reads the low and high source bytes, presents the 11 data bits to the
// external combinational encoder, latches the 16-bit codeword and writes it back as two bytes,
// high byte first. Five cycles per message. The memory port is owned while busy.
module hamming_seq_ctrl #(
    parameter int unsigned NUM_MSG  = 15,
    parameter int unsigned SRC_BASE = 0,
    parameter int unsigned DST_BASE = 30,
    parameter int unsigned AW       = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,      // synchronous, active low
    input  logic          i_init,
    output logic          o_done,
    output logic          o_busy,
    output logic          o_fmt_err,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_we,
    output logic [7:0]    o_mem_wdata,
    input  logic [7:0]    i_mem_rdata,
    output logic [10:0]   o_enc_din,
    input  logic [15:0]   i_enc_code
);

    // Index width: enough to hold NUM_MSG-1, never narrower than one bit.
    localparam int unsigned IW = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MSG - 1);
    localparam logic [AW-1:0] SRC_A    = AW'(SRC_BASE);
    localparam logic [AW-1:0] DST_A    = AW'(DST_BASE);

    // Elaboration-time sanity: at least one message and no address wrap in either region.
    if (NUM_MSG < 1) begin : g_chk_num
        $error("hamming_seq_ctrl: NUM_MSG must be >= 1");
    end
    if ((longint'(SRC_BASE) + 2 * longint'(NUM_MSG) - 1) >= (longint'(1) << AW)) begin : g_chk_src
        $error("hamming_seq_ctrl: source region exceeds address space");
    end
    if ((longint'(DST_BASE) + 2 * longint'(NUM_MSG) - 1) >= (longint'(1) << AW)) begin : g_chk_dst
        $error("hamming_seq_ctrl: destination region exceeds address space");
    end

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRdLo = 3'd1,
        StRdHi = 3'd2,
        StEnc  = 3'd3,
        StWrHi = 3'd4,
        StWrLo = 3'd5,
        StDone = 3'd6
    } state_e;

    state_e          r_state;
    logic [IW-1:0]   r_idx;
    logic [7:0]      r_lo;
    logic [2:0]      r_hi;
    logic [15:0]     r_code;
    logic            r_done;
    logic            r_fmt_err;

    state_e          w_state_nxt;
    logic [IW-1:0]   w_idx_nxt;
    logic [7:0]      w_lo_nxt;
    logic [2:0]      w_hi_nxt;
    logic [15:0]     w_code_nxt;
    logic            w_done_nxt;
    logic            w_fmt_err_nxt;

    logic [AW-1:0]   w_msg_off;
    logic [AW-1:0]   w_src_lo;
    logic [AW-1:0]   w_src_hi;
    logic [AW-1:0]   w_dst_lo;
    logic [AW-1:0]   w_dst_hi;
    logic [AW-1:0]   w_mem_addr;
    logic            w_mem_we;
    logic [7:0]      w_mem_wdata;

    // Per-message byte addresses; the elaboration checks guarantee these never wrap.
    always_comb begin
        w_msg_off = AW'({r_idx, 1'b0});
        w_src_lo  = SRC_A + w_msg_off;
        w_src_hi  = w_src_lo + AW'(1);
        w_dst_lo  = DST_A + w_msg_off;
        w_dst_hi  = w_dst_lo + AW'(1);
    end

    // State register and datapath latches; reset aborts any run in progress.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state   <= StIdle;
            r_idx     <= '0;
            r_lo      <= '0;
            r_hi      <= '0;
            r_code    <= '0;
            r_done    <= 1'b0;
            r_fmt_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_lo      <= w_lo_nxt;
            r_hi      <= w_hi_nxt;
            r_code    <= w_code_nxt;
            r_done    <= w_done_nxt;
            r_fmt_err <= w_fmt_err_nxt;
        end
    end

    // Next-state and memory-port drive; the port is idle (all zero) outside a run.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_lo_nxt      = r_lo;
        w_hi_nxt      = r_hi;
        w_code_nxt    = r_code;
        w_done_nxt    = r_done;
        w_fmt_err_nxt = r_fmt_err;
        w_mem_addr    = '0;
        w_mem_we      = 1'b0;
        w_mem_wdata   = '0;

        unique case (r_state)
            StIdle, StDone: begin
                // init is only honoured here, so a request during a run is simply dropped.
                if (i_init) begin
                    w_idx_nxt     = '0;
                    w_fmt_err_nxt = 1'b0;
                    w_done_nxt    = 1'b0;
                    w_state_nxt   = StRdLo;
                end
            end
            StRdLo: begin
                w_mem_addr  = w_src_lo;
                w_lo_nxt    = i_mem_rdata;
                w_state_nxt = StRdHi;
            end
            StRdHi: begin
                w_mem_addr    = w_src_hi;
                w_hi_nxt      = i_mem_rdata[2:0];
                // Any stray bit above the 11 data bits marks the run as malformed.
                w_fmt_err_nxt = r_fmt_err | (|i_mem_rdata[7:3]);
                w_state_nxt   = StEnc;
            end
            StEnc: begin
                w_code_nxt  = i_enc_code;
                w_state_nxt = StWrHi;
            end
            StWrHi: begin
                w_mem_addr  = w_dst_hi;
                w_mem_wdata = r_code[15:8];
                w_mem_we    = 1'b1;
                w_state_nxt = StWrLo;
            end
            StWrLo: begin
                w_mem_addr  = w_dst_lo;
                w_mem_wdata = r_code[7:0];
                w_mem_we    = 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = StDone;
                end else begin
                    w_idx_nxt   = r_idx + IW'(1);
                    w_state_nxt = StRdLo;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Encoder input comes straight from the latches, so it only moves when they update.
    always_comb begin
        o_enc_din   = {r_hi, r_lo};
        o_busy      = (r_state != StIdle) && (r_state != StDone);
        o_done      = r_done;
        o_fmt_err   = r_fmt_err;
        o_mem_addr  = w_mem_addr;
        o_mem_we    = w_mem_we;
        o_mem_wdata = w_mem_wdata;
    end

endmodule

// File: tb/tb_hamming_seq_ctrl.sv
// Bench for hamming_seq_ctrl: byte memory model, Hamming(16,11) encoder model, write scoreboard,
// a table of hand-computed codewords and hand-written abort / init-handshake sequences.
module tb_hamming_seq_ctrl;

    localparam int NUM_MSG = 15;
    localparam int SRC     = 0;
    localparam int DST     = 30;

    logic        clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_init = 1'b0;
    logic        o_done;
    logic        o_busy;
    logic        o_fmt_err;
    logic [7:0]  o_mem_addr;
    logic        o_mem_we;
    logic [7:0]  o_mem_wdata;
    logic [7:0]  i_mem_rdata;
    logic [10:0] o_enc_din;
    logic [15:0] i_enc_code;

    logic [7:0]  mem [0:255];
    logic [10:0] cap_din [0:NUM_MSG-1];

    typedef struct {
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [10:0] din;
        logic [15:0] code;
    } vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  data;
        logic [10:0] din;
    } wr_t;

    vec_t tbl [0:5];
    wr_t  sb_q [$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_we = 0;

    // Parity positions 1,2,4,8 plus overall even parity in bit 0; data fills the rest.
    function automatic logic [15:0] enc_model(input logic [10:0] d);
        int          pos [0:10];
        logic [15:0] c;
        logic        x;
        pos = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
        c = '0;
        for (int i = 0; i < 11; i++) c[pos[i]] = d[i];
        for (int p = 1; p < 16; p = p * 2) begin
            x = 1'b0;
            for (int k = 1; k < 16; k++) if (((k & p) != 0) && (k != p)) x ^= c[k];
            c[p] = x;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    always #5 clk = ~clk;

    assign i_mem_rdata = mem[o_mem_addr];
    assign i_enc_code  = enc_model(o_enc_din);

    hamming_seq_ctrl #(
        .NUM_MSG  (NUM_MSG),
        .SRC_BASE (SRC),
        .DST_BASE (DST),
        .AW       (8)
    ) u_dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_init      (i_init),
        .o_done      (o_done),
        .o_busy      (o_busy),
        .o_fmt_err   (o_fmt_err),
        .o_mem_addr  (o_mem_addr),
        .o_mem_we    (o_mem_we),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata),
        .o_enc_din   (o_enc_din),
        .i_enc_code  (i_enc_code)
    );

    always @(posedge clk) begin
        if (o_mem_we === 1'b1) mem[o_mem_addr] <= o_mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every write cycle must match the next expected write.
    always @(negedge clk) begin
        if (o_mem_we === 1'b1) begin
            wr_t e;
            int  m;
            n_we++;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_unexpected_write: got addr %0h data %0h, expected no write",
                         o_mem_addr, o_mem_wdata);
            end else begin
                e = sb_q.pop_front();
                chk("sb_addr", 32'(o_mem_addr), 32'(e.addr));
                chk("sb_data", 32'(o_mem_wdata), 32'(e.data));
                chk("sb_din", 32'(o_enc_din), 32'(e.din));
                m = (int'(o_mem_addr) - DST) / 2;
                if (m >= 0 && m < NUM_MSG) cap_din[m] = o_enc_din;
            end
        end
    end

    task automatic push_expect();
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [10:0] din;
        logic [15:0] code;
        wr_t         w;
        for (int i = 0; i < NUM_MSG; i++) begin
            lo   = mem[SRC + 2 * i];
            hi   = mem[SRC + 2 * i + 1];
            din  = {hi[2:0], lo};
            code = enc_model(din);
            w.addr = 8'(DST + 2 * i + 1); w.data = code[15:8]; w.din = din;
            sb_q.push_back(w);
            w.addr = 8'(DST + 2 * i);     w.data = code[7:0];  w.din = din;
            sb_q.push_back(w);
        end
    endtask

    task automatic fill_dst(input logic [7:0] v);
        for (int i = 0; i < 2 * NUM_MSG; i++) mem[DST + i] = v;
    endtask

    task automatic fill_src_clean();
        for (int i = 0; i < NUM_MSG; i++) begin
            mem[SRC + 2 * i]     = 8'($urandom_range(0, 255));
            mem[SRC + 2 * i + 1] = 8'($urandom_range(0, 7));
        end
    endtask

    // Pulse init for one edge; returns at the negedge after the sampling edge (run cycle 0).
    task automatic start_run();
        push_expect();
        n_we = 0;
        @(negedge clk) i_init = 1'b1;
        @(posedge clk);
        @(negedge clk) i_init = 1'b0;
        chk("start_busy", 32'(o_busy), 1);
        chk("start_done", 32'(o_done), 0);
        chk("start_fmt_clr", 32'(o_fmt_err), 0);
    endtask

    // Counts edges until done; optional mid-run pulse, init hold, abort and fmt_err probe.
    // lat: edges from init to done, 0 if aborted, -1 on timeout.
    task automatic wait_done(input int cyc0, input int pulse_at, input int hold_at,
                             input int abort_at, input int fmt_at, output int lat);
        int cyc;
        int busy_bad;
        cyc = cyc0;
        busy_bad = 0;
        lat = -1;
        while (lat < 0 && cyc < 300) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (o_done) lat = cyc;
            else if (!o_busy) busy_bad++;
            if (fmt_at > 0 && cyc == fmt_at - 1) chk("fmt_before_rdhi", 32'(o_fmt_err), 0);
            if (fmt_at > 0 && cyc == fmt_at) chk("fmt_after_rdhi", 32'(o_fmt_err), 1);
            if (cyc == pulse_at - 1) i_init = 1'b1;
            if (cyc == pulse_at) i_init = 1'b0;
            if (hold_at > 0 && cyc == hold_at) i_init = 1'b1;
            if (cyc == abort_at - 1) begin
                chk("abort_wrlo_we", 32'(o_mem_we), 1);
                chk("abort_wrlo_addr", 32'(o_mem_addr), DST + 14);
                i_reset = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk("abort_busy", 32'(o_busy), 0);
                chk("abort_done", 32'(o_done), 0);
                chk("abort_we", 32'(o_mem_we), 0);
                chk("abort_addr", 32'(o_mem_addr), 0);
                i_reset = 1'b1;
                sb_q.delete();
                lat = 0;
            end
        end
        if (lat < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", cyc);
        end
        chk("busy_during_run", 32'(busy_bad), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bad;
        logic [7:0] pre [0:255];

        tbl[0] = '{8'hFF, 8'h07, 11'h7FF, 16'hFFFF};
        tbl[1] = '{8'h01, 8'h00, 11'h001, 16'h000F};
        tbl[2] = '{8'h00, 8'hF9, 11'h100, 16'h2112};
        tbl[3] = '{8'h02, 8'h00, 11'h002, 16'h0033};
        tbl[4] = '{8'h80, 8'h00, 11'h080, 16'h1111};
        tbl[5] = '{8'h00, 8'h04, 11'h400, 16'h8117};

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // Reset state
        i_reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_fmt", 32'(o_fmt_err), 0);
        chk("rst_we", 32'(o_mem_we), 0);
        chk("rst_addr", 32'(o_mem_addr), 0);
        chk("rst_wdata", 32'(o_mem_wdata), 0);
        chk("rst_enc_din", 32'(o_enc_din), 0);
        i_reset = 1'b1;

        // All-zero messages
        fill_dst(8'hA5);
        start_run();
        wait_done(0, 0, 0, 0, 0, lat);
        chk("zero_latency", 32'(lat), 75);
        chk("zero_we_count", 32'(n_we), 30);
        chk("zero_fmt", 32'(o_fmt_err), 0);
        chk("zero_sb_empty", 32'(sb_q.size()), 0);
        bad = 0;
        for (int i = 0; i < 2 * NUM_MSG; i++) if (mem[DST + i] !== 8'h00) bad++;
        chk("zero_codes", 32'(bad), 0);
        repeat (3) @(negedge clk);
        chk("done_held", 32'(o_done), 1);
        chk("done_not_busy", 32'(o_busy), 0);
        chk("done_addr_zero", 32'(o_mem_addr), 0);

        // Table vectors in messages 0..5, random clean data elsewhere
        fill_src_clean();
        for (int i = 0; i < 6; i++) begin
            mem[SRC + 2 * i]     = tbl[i].lo;
            mem[SRC + 2 * i + 1] = tbl[i].hi;
        end
        fill_dst(8'hA5);
        start_run();
        wait_done(0, 0, 0, 0, 12, lat);
        chk("tbl_latency", 32'(lat), 75);
        chk("tbl_fmt_sticky", 32'(o_fmt_err), 1);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("tbl%0d_din", i), 32'(cap_din[i]), 32'(tbl[i].din));
            chk($sformatf("tbl%0d_code", i), 32'({mem[DST + 2 * i + 1], mem[DST + 2 * i]}),
                32'(tbl[i].code));
        end
        bad = 0;
        for (int i = 0; i < NUM_MSG; i++) begin
            if ({mem[DST + 2 * i + 1], mem[DST + 2 * i]} !==
                enc_model({mem[SRC + 2 * i + 1][2:0], mem[SRC + 2 * i]})) bad++;
        end
        chk("model_all_msgs", 32'(bad), 0);

        // Second init clears the sticky format error
        fill_src_clean();
        start_run();
        wait_done(0, 0, 0, 0, 0, lat);
        chk("clean_latency", 32'(lat), 75);
        chk("clean_fmt", 32'(o_fmt_err), 0);

        // Reset during WR_LO of message 7
        fill_src_clean();
        fill_dst(8'hA5);
        for (int i = 0; i < 256; i++) pre[i] = mem[i];
        start_run();
        wait_done(0, 0, 0, 40, 0, lat);
        chk("abort_flag", 32'(lat), 0);
        chk("abort_we_count", 32'(n_we), 16);
        repeat (4) @(negedge clk);
        chk("abort_stay_idle", 32'(o_busy), 0);
        bad = 0;
        for (int a = 46; a < 60; a++) if (mem[a] !== pre[a]) bad++;
        chk("abort_untouched", 32'(bad), 0);
        start_run();
        wait_done(0, 0, 0, 0, 0, lat);
        chk("rerun_latency", 32'(lat), 75);
        chk("rerun_we_count", 32'(n_we), 30);

        // Init pulse mid-run ignored; init held across done restarts after one done cycle
        fill_src_clean();
        start_run();
        wait_done(0, 20, 70, 0, 0, lat);
        chk("pulse_latency", 32'(lat), 75);
        chk("pulse_we_count", 32'(n_we), 30);
        @(posedge clk);
        @(negedge clk);
        chk("hold_done_one_cycle", 32'(o_done), 0);
        chk("hold_restart_busy", 32'(o_busy), 1);
        push_expect();
        n_we = 0;
        i_init = 1'b0;
        wait_done(0, 0, 0, 0, 0, lat);
        chk("hold_run2_latency", 32'(lat), 75);
        chk("hold_run2_we_count", 32'(n_we), 30);
        chk("hold_sb_empty", 32'(sb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hamming_seq_ctrl.md
Name: hamming_seq_ctrl

Overview:
- Sequences the program-1 Hamming(16,11) encode pass over data memory.
- For each of NUM_MSG messages it reads the 2-byte source word, presents the 11 data bits to the external combinational encoder, latches the 16-bit codeword, and writes it back as 2 bytes.
- Sits between top_level's init/done handshake and the dm1 data memory port plus the encoder datapath; it owns the memory port while busy.

Parameters:
- NUM_MSG, 15, number of messages processed per run (must be >= 1).
- SRC_BASE, 0, byte address of message 0 low byte.
- DST_BASE, 30, byte address of codeword 0 low byte.
- AW, 8, memory address width. Elaboration-time check: DST_BASE+2*NUM_MSG-1 < 2**AW and SRC_BASE+2*NUM_MSG-1 < 2**AW.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- init  in  1  start request, level-sampled.
- done  out  1  run complete, held high until next start or reset.
- busy  out  1  high while a run is in progress.
- fmt_err  out  1  sticky: some source high byte had bits [7:3] nonzero.
- mem_addr  out  AW  data memory byte address.
- mem_we  out  1  data memory write enable.
- mem_wdata  out  8  data memory write byte.
- mem_rdata  in  8  data memory read byte; combinational read of mem_addr.
- enc_din  out  11  data bits to encoder, {hi[2:0], lo[7:0]}.
- enc_code  in  16  encoder codeword, combinational from enc_din.

Behaviour:
- Reset (reset==0 at an edge) overrides everything:
  - state=IDLE; idx=0; lo_q, hi_q, code_q = 0.
  - done=0, busy=0, fmt_err=0, mem_we=0, mem_addr=0, mem_wdata=0, enc_din=0.
- Reset mid-run aborts immediately. Bytes already written stay in memory; no further writes occur.
- States: IDLE, RD_LO, RD_HI, ENC, WR_HI, WR_LO, DONE. busy=1 in all states except IDLE and DONE.
- IDLE / DONE:
  - mem_we=0.
  - If init==1 at an edge: idx=0, fmt_err=0, done=0, go to RD_LO.
  - Otherwise hold. DONE keeps done=1.
- RD_LO: mem_addr=SRC_BASE+2*idx; at the edge lo_q<=mem_rdata; go to RD_HI.
- RD_HI: mem_addr=SRC_BASE+2*idx+1; at the edge hi_q<=mem_rdata[2:0]; fmt_err<=fmt_err|(|mem_rdata[7:3]); go to ENC.
- ENC: enc_din={hi_q,lo_q}; at the edge code_q<=enc_code; go to WR_HI.
- WR_HI: mem_addr=DST_BASE+2*idx+1, mem_wdata=code_q[15:8], mem_we=1; go to WR_LO.
- WR_LO:
  - mem_addr=DST_BASE+2*idx, mem_wdata=code_q[7:0], mem_we=1.
  - If idx==NUM_MSG-1: go to DONE, done<=1.
  - Else idx<=idx+1, go to RD_LO.
- Outputs:
  - enc_din holds {hi_q,lo_q} in every state; it changes only when the latches update.
  - mem_we=1 only in WR_HI and WR_LO, exactly 2*NUM_MSG write cycles per run.
  - mem_addr and mem_wdata are 0 in IDLE and DONE.
- Latency:
  - 5 cycles per message.
  - done rises at the edge 5*NUM_MSG cycles after the edge that sampled init (75 for the default).
  - busy falls at the same edge.
- init while busy is ignored; no restart and no effect on idx.
- init held high continuously: the run completes, DONE is entered for exactly one cycle with done=1, then a new run starts and done drops.
- Arithmetic: addresses are computed at AW bits, with no wrap permitted (see elaboration check). idx width is clog2(NUM_MSG), min 1.
- The source region may overlap the destination region only if the user accepts overwrite order: hi byte first, then lo byte, per message.

Test Plan:
- Reset, then mem[0..29]=0, init pulse 1 cycle -> done rises 75 cycles later; mem[30..59] all 0x00; fmt_err=0; exactly 30 mem_we cycles observed.
- Message 0 = {mem[1]=0x07, mem[0]=0xFF} -> enc_din=11'h7FF during ENC of idx 0; mem[31]=0xFF, mem[30]=0xFF.
- Message 1 = {mem[3]=0x00, mem[2]=0x01} -> enc_din=11'h001; mem[33]=0x00, mem[32]=0x0F. Compare all 15 results against the bench parity model for 15 random messages: 15/15 match.
- mem[5]=0xF9 (bits [7:3] set) -> fmt_err=1 after message 2's RD_HI and sticky to done; enc_din[10:8]=3'b001. A second init clears fmt_err.
- Pull reset low during WR_LO of idx 7 -> next edge: state IDLE, busy=0, done=0, mem_we=0; mem[46..59] unchanged from pre-run. A later init reruns fully and done rises after 75 cycles.
- Pulse init at cycle 20 of a run and hold init high from done -> first pulse ignored (done still at 75); with init held, done is high for exactly 1 cycle, then busy=1 and a second run begins.
